sample_unpacker: RTL
====================

// Module: sample_unpacker
// PURPOSE
//  Downstream neighbour of the APU sample fetcher. Accepts 64-bit DDR3 sample chunks over
//  the chunk/chunk_valid/chunk_ack handshake and buffers them in a small FIFO. Unpacks each
//  chunk into two 16-bit stereo frames and presents one frame per I2S frame request.
//  Outputs silence plus an underrun flag when starved.
// PARAMETERS
//  FIFO_DEPTH      4   chunk FIFO entries; power of 2, >= 2
//  CHUNKS_PER_BUF  64  chunks per 512-byte sample buffer; sets the buffer_done cadence
// PORTS
//  clock         in   1   system clock; single clock domain
//  reset_l       in   1   asynchronous active-low reset
//  enable        in   1   playback enable; low = flush and output silence
//  chunk         in   64  sample chunk from fetcher
//  chunk_valid   in   1   chunk holds valid data
//  chunk_ack     out  1   chunk accepted this cycle (combinational)
//  sample_req    in   1   1-cycle pulse from I2S requesting the next stereo frame
//  sample_l      out  16  left sample, two's complement
//  sample_r      out  16  right sample, two's complement
//  sample_valid  out  1   1-cycle pulse: sample_l/r updated
//  underrun      out  1   1-cycle pulse: request served with silence (FIFO empty)
//  buffer_done   out  1   1-cycle pulse: final frame of the CHUNKS_PER_BUF-th chunk played
// BEHAVIOUR
//  Reset (async, reset_l=0):
//   - FIFO empty; half=0; chunk counter=0.
//   - sample_l=sample_r=0; sample_valid=underrun=buffer_done=0.
//  Chunk layout (little-endian):
//   - frame0: L=chunk[15:0],  R=chunk[31:16].
//   - frame1: L=chunk[47:32], R=chunk[63:48].
//  Push:
//   - chunk_ack = chunk_valid & (~full | ~enable).
//   - Data is written only when enable=1. With enable=0, chunks are acked and discarded
//     so the fetcher drains.
//   - Full is evaluated on the current count; no same-cycle pop bypass.
//  Pop (sample_req=1, enable=1):
//   - Not empty: next cycle sample_l/r = head frame selected by half; sample_valid=1.
//     If half=1, pop the head and advance the chunk counter. half toggles.
//   - Empty: next cycle sample_l/r=0, sample_valid=1, underrun=1. half and counter
//     unchanged.
//   - Latency: exactly 1 cycle from sample_req to sample_valid.
//   - sample_l/r hold their value between requests.
//  Simultaneous push and pop of a full chunk: count unchanged. Pointers wrap modulo
//  FIFO_DEPTH. The count field is log2(FIFO_DEPTH)+1 bits wide.
//  Chunk counter:
//   - Increments on each pop.
//   - On reaching CHUNKS_PER_BUF-1 with a pop, wraps to 0 and pulses buffer_done in the
//     same cycle as that frame's sample_valid.
//  enable=0 (synchronous effect, from the next edge):
//   - FIFO flushed; half=0; counter=0.
//   - sample_req answered with sample_l/r=0 and sample_valid=1. No underrun, no buffer_done.
//   - A mid-chunk disable discards the remaining frame.
//  Reset mid-operation: all state returns to reset values immediately. Buffered chunks are
//  lost.
// TESTING
//  1) Push chunk 64'h4444_3333_2222_1111, then 2 sample_req -> (L,R)=(1111,2222) then
//     (3333,4444). Each result appears 1 cycle after its request. FIFO empty afterwards.
//  2) Hold chunk_valid=1 with no requests -> exactly FIFO_DEPTH acks, then chunk_ack=0.
//     One frame1 pop -> chunk_ack=1 the following cycle.
//  3) Request with empty FIFO -> sample_l=sample_r=0, sample_valid=1, underrun=1. Then
//     push a chunk and request -> frame0 returned (half not advanced by the underrun).
//  4) Stream 64 chunks (128 requests) -> buffer_done pulses once, with the 128th
//     sample_valid. Counter wraps, and the next pulse comes after 128 more frames.
//  5) Push a chunk, play frame0, drop enable for 1 cycle, push a new chunk, request ->
//     new chunk's frame0 returned. Chunks offered while disabled are acked and never
//     played.
//  6) Assert reset_l=0 asynchronously mid-stream with the FIFO half full -> all outputs
//     0 before the next clock edge; no stale data after release.

Source files
------------

// File: rtl/sample_unpacker_if.sv
// Handshake bundle between the sample fetcher / I2S side and the sample unpacker.
//   enable        playback enable
//   chunk         64-bit sample chunk from the fetcher
//   chunk_valid   chunk holds valid data
//   chunk_ack     chunk accepted this cycle
//   sample_req    1-cycle frame request from I2S
//   sample_l/r    left/right 16-bit samples
//   sample_valid  samples updated this cycle
//   underrun      request served with silence
//   buffer_done   final frame of a sample buffer played
interface sample_unpacker_if;
  logic        enable;
  logic [63:0] chunk;
  logic        chunk_valid;
  logic        chunk_ack;
  logic        sample_req;
  logic [15:0] sample_l;
  logic [15:0] sample_r;
  logic        sample_valid;
  logic        underrun;
  logic        buffer_done;

  modport master (
    output enable, chunk, chunk_valid, sample_req,
    input  chunk_ack, sample_l, sample_r, sample_valid, underrun, buffer_done
  );

  modport slave (
    input  enable, chunk, chunk_valid, sample_req,
    output chunk_ack, sample_l, sample_r, sample_valid, underrun, buffer_done
  );
endinterface

// File: rtl/sample_unpacker.sv
// Sample unpacker: buffers 64-bit chunks in a small FIFO and plays them out as two
// 16-bit stereo frames, one per I2S request, with silence + underrun when starved.
// Ports:
//   clock    system clock
//   reset_l  asynchronous active-low reset
//   bus      sample_unpacker_if.slave (chunk handshake in, frame outputs out)
module sample_unpacker #(
  parameter int FIFO_DEPTH     = 4,
  parameter int CHUNKS_PER_BUF = 64
) (
  input logic          clock,
  input logic          reset_l,
  sample_unpacker_if.slave bus
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int NW = (CHUNKS_PER_BUF > 1) ? $clog2(CHUNKS_PER_BUF) : 1;

  logic [63:0]   mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          half;
  logic [NW-1:0] chunk_cnt;

  logic          full;
  logic          empty;
  logic          push;
  logic          serve;
  logic          pop;
  logic          last_chunk;
  logic [63:0]   head;
  logic [31:0]   head_frame;

  logic [15:0]   sample_l_q;
  logic [15:0]   sample_r_q;
  logic          sample_valid_q;
  logic          underrun_q;
  logic          buffer_done_q;

  assign full  = (count == CW'(FIFO_DEPTH));
  assign empty = (count == '0);

  // While disabled every offered chunk is acked and dropped so the fetcher drains.
  assign bus.chunk_ack = bus.chunk_valid & (~full | ~bus.enable);
  assign push          = bus.chunk_valid & ~full & bus.enable;
  assign serve         = bus.sample_req & bus.enable & ~empty;
  assign pop           = serve & half;
  assign last_chunk    = (chunk_cnt == NW'(CHUNKS_PER_BUF - 1));

  assign head       = mem[rd_ptr];
  assign head_frame = half ? head[63:32] : head[31:0];

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= bus.chunk;
  end

  always_ff @(posedge clock or negedge reset_l) begin
    if (!reset_l) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      half      <= 1'b0;
      chunk_cnt <= '0;
    end else if (!bus.enable) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      half      <= 1'b0;
      chunk_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (!push && pop) count <= count - CW'(1);
      if (serve) half <= ~half;
      if (pop)   chunk_cnt <= last_chunk ? '0 : chunk_cnt + NW'(1);
    end
  end

  // Every request gets a sample_valid one cycle later; silence unless a frame was served.
  always_ff @(posedge clock or negedge reset_l) begin
    if (!reset_l) begin
      sample_l_q     <= '0;
      sample_r_q     <= '0;
      sample_valid_q <= 1'b0;
      underrun_q     <= 1'b0;
      buffer_done_q  <= 1'b0;
    end else begin
      sample_valid_q <= bus.sample_req;
      underrun_q     <= bus.sample_req & bus.enable & empty;
      buffer_done_q  <= pop & last_chunk;
      if (bus.sample_req) begin
        sample_l_q <= serve ? head_frame[15:0]  : 16'h0000;
        sample_r_q <= serve ? head_frame[31:16] : 16'h0000;
      end
    end
  end

  assign bus.sample_l     = sample_l_q;
  assign bus.sample_r     = sample_r_q;
  assign bus.sample_valid = sample_valid_q;
  assign bus.underrun     = underrun_q;
  assign bus.buffer_done  = buffer_done_q;

endmodule
